// File: rtl/pipeline_flow_ctrl_pkg.sv
// Shared control types for the pipeline flow controller: FSM states and the
// per-stage enable/clear bundle handed to the pipeline register banks.
package pipeline_flow_ctrl_pkg;

   localparam int unsigned BOOT_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic en_pc;
      logic en_fd;
      logic clr_fd;
      logic en_de;
      logic clr_de;
      logic en_em;
      logic en_mw;
   } stage_ctrl_t;

   // Boot flushes F/D and D/E while the PC stays parked on the reset vector.
   localparam stage_ctrl_t BOOT_CTRL = '{
      en_pc:  1'b0,
      en_fd:  1'b1,
      clr_fd: 1'b1,
      en_de:  1'b1,
      clr_de: 1'b1,
      en_em:  1'b1,
      en_mw:  1'b1
   };

endpackage

// File: rtl/pipeline_flow_ctrl_sat_counter.sv
// Saturating up-counter stepping by 0, 1 or 2 per cycle, cleared by a
// synchronous active-low reset.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic [1:0]       iInc,
   output logic [CNT_W-1:0] oCount
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W:0]   sum;

   // One extra bit catches the carry; a carry means the add ran past all-ones.
   always_comb begin
      sum     = {1'b0, count_q} + {{(CNT_W-1){1'b0}}, iInc};
      count_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign oCount = count_q;

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline flow controller: merges hazard, redirect and memory-wait requests
// into per-stage enable/clear strobes, tracks stage valids and keeps counters.
module pipeline_flow_ctrl
   import pipeline_flow_ctrl_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             iStallF,
   input  logic             iStallD,
   input  logic             iFlushE,
   input  logic             iRedirectD,
   input  logic             iFetchBusyF,
   input  logic             iMemBusyM,
   output logic             oEnPC,
   output logic             oEnFD,
   output logic             oClrFD,
   output logic             oEnDE,
   output logic             oClrDE,
   output logic             oEnEM,
   output logic             oEnMW,
   output logic             oValidD,
   output logic             oValidE,
   output logic             oValidM,
   output logic             oValidW,
   output logic [1:0]       oState,
   output logic [CNT_W-1:0] oStallCycles,
   output logic [CNT_W-1:0] oFlushCount,
   output logic [CNT_W-1:0] oRetireCount
);

   state_e                state_q, state_d;
   logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
   stage_ctrl_t           ctrl;
   logic                  stall;
   logic                  valid_d_q, valid_e_q, valid_m_q, valid_w_q;
   logic                  not_boot;
   logic [1:0]            stall_inc, flush_inc, retire_inc;

   assign stall = iStallF | iStallD;

   always_comb begin
      ctrl       = '0;
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      if (state_q == ST_BOOT) begin
         ctrl       = BOOT_CTRL;
         boot_cnt_d = boot_cnt_q + 1'b1;
         if (boot_cnt_q == BOOT_CNT_W'(BOOT_CYCLES - 1)) begin
            state_d = ST_RUN;
         end
      end else if (iMemBusyM) begin
         state_d = ST_MEM_WAIT;
      end else begin
         // Memory released: RUN rules apply in this very cycle.
         state_d     = ST_RUN;
         ctrl.en_em  = 1'b1;
         ctrl.en_mw  = 1'b1;
         ctrl.en_de  = 1'b1;
         ctrl.clr_de = iFlushE;
         if (stall) begin
            ctrl.en_de = iFlushE;
         end else if (iRedirectD) begin
            ctrl.en_pc  = 1'b1;
            ctrl.en_fd  = 1'b1;
            ctrl.clr_fd = 1'b1;
         end else if (iFetchBusyF) begin
            ctrl.en_fd  = 1'b1;
            ctrl.clr_fd = 1'b1;
         end else begin
            ctrl.en_pc = 1'b1;
            ctrl.en_fd = 1'b1;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         state_q    <= ST_BOOT;
         boot_cnt_q <= '0;
         valid_d_q  <= 1'b0;
         valid_e_q  <= 1'b0;
         valid_m_q  <= 1'b0;
         valid_w_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         if (ctrl.clr_fd) begin
            valid_d_q <= 1'b0;
         end else if (ctrl.en_fd) begin
            valid_d_q <= 1'b1;
         end
         if (ctrl.clr_de) begin
            valid_e_q <= 1'b0;
         end else if (ctrl.en_de) begin
            valid_e_q <= valid_d_q;
         end
         if (ctrl.en_em) begin
            valid_m_q <= valid_e_q;
         end
         if (ctrl.en_mw) begin
            valid_w_q <= valid_m_q;
         end
      end
   end

   assign not_boot   = (state_q != ST_BOOT);
   assign stall_inc  = {1'b0, not_boot & ~ctrl.en_pc};
   assign flush_inc  = not_boot ? ({1'b0, ctrl.clr_de & iFlushE} + {1'b0, ctrl.clr_fd & iRedirectD})
                                : 2'd0;
   assign retire_inc = {1'b0, not_boot & ctrl.en_mw & valid_w_q};

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iInc   (stall_inc),
      .oCount (oStallCycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iInc   (flush_inc),
      .oCount (oFlushCount)
   );

   sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iInc   (retire_inc),
      .oCount (oRetireCount)
   );

   assign oEnPC   = ctrl.en_pc;
   assign oEnFD   = ctrl.en_fd;
   assign oClrFD  = ctrl.clr_fd;
   assign oEnDE   = ctrl.en_de;
   assign oClrDE  = ctrl.clr_de;
   assign oEnEM   = ctrl.en_em;
   assign oEnMW   = ctrl.en_mw;
   assign oValidD = valid_d_q;
   assign oValidE = valid_e_q;
   assign oValidM = valid_m_q;
   assign oValidW = valid_w_q;
   assign oState  = state_q;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl: a 32-bit counter instance and a 4-bit
// counter instance share all inputs; the narrow one exercises saturation.
module tb_pipeline_flow_ctrl;

   logic clk;
   logic rst_n;
   logic stall_f, stall_d, flush_e, redirect_d, fetch_busy, mem_busy;

   logic        en_pc, en_fd, clr_fd, en_de, clr_de, en_em, en_mw;
   logic        v_d, v_e, v_m, v_w;
   logic [1:0]  state;
   logic [31:0] stall_cnt, flush_cnt, retire_cnt;

   logic        en_pc4, en_fd4, clr_fd4, en_de4, clr_de4, en_em4, en_mw4;
   logic        v_d4, v_e4, v_m4, v_w4;
   logic [1:0]  state4;
   logic [3:0]  stall_cnt4, flush_cnt4, retire_cnt4;

   int n_tests = 0;
   int n_fail  = 0;

   pipeline_flow_ctrl #(.BOOT_CYCLES(4), .CNT_W(32)) dut (
      .iClk(clk), .iRstN(rst_n),
      .iStallF(stall_f), .iStallD(stall_d), .iFlushE(flush_e),
      .iRedirectD(redirect_d), .iFetchBusyF(fetch_busy), .iMemBusyM(mem_busy),
      .oEnPC(en_pc), .oEnFD(en_fd), .oClrFD(clr_fd), .oEnDE(en_de), .oClrDE(clr_de),
      .oEnEM(en_em), .oEnMW(en_mw),
      .oValidD(v_d), .oValidE(v_e), .oValidM(v_m), .oValidW(v_w),
      .oState(state),
      .oStallCycles(stall_cnt), .oFlushCount(flush_cnt), .oRetireCount(retire_cnt)
   );

   pipeline_flow_ctrl #(.BOOT_CYCLES(4), .CNT_W(4)) dut4 (
      .iClk(clk), .iRstN(rst_n),
      .iStallF(stall_f), .iStallD(stall_d), .iFlushE(flush_e),
      .iRedirectD(redirect_d), .iFetchBusyF(fetch_busy), .iMemBusyM(mem_busy),
      .oEnPC(en_pc4), .oEnFD(en_fd4), .oClrFD(clr_fd4), .oEnDE(en_de4), .oClrDE(clr_de4),
      .oEnEM(en_em4), .oEnMW(en_mw4),
      .oValidD(v_d4), .oValidE(v_e4), .oValidM(v_m4), .oValidW(v_w4),
      .oState(state4),
      .oStallCycles(stall_cnt4), .oFlushCount(flush_cnt4), .oRetireCount(retire_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic sf, input logic sd, input logic fe,
                        input logic rd, input logic fb, input logic mb);
      stall_f    = sf;
      stall_d    = sd;
      flush_e    = fe;
      redirect_d = rd;
      fetch_busy = fb;
      mem_busy   = mb;
      #1;
   endtask

   task automatic chk_valids(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, v_d, v_e, v_m, v_w}, {28'd0, exp});
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("rst_state", state, 0);
      chk_valids("rst_valids", 4'b0000);
      chk("rst_cnts", stall_cnt | flush_cnt | retire_cnt, 0);
      chk("rst_cnts4", {20'd0, stall_cnt4, flush_cnt4, retire_cnt4}, 0);

      // Boot: exactly four cycles with the PC held.
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("boot%0d_enpc", c), en_pc, 0);
         chk($sformatf("boot%0d_state", c), state, 0);
         chk($sformatf("boot%0d_clr", c), {30'd0, clr_fd, clr_de}, 32'h3);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      chk("run_state", state, 1);
      chk("run_enpc", en_pc, 1);
      chk_valids("run_valids0", 4'b0000);
      tick();
      chk_valids("run_valids1", 4'b1000);
      repeat (3) tick();
      chk_valids("fill_valids", 4'b1111);
      chk("fill_cnts", stall_cnt | flush_cnt | retire_cnt, 0);

      // Load-use stall with bubble into D/E.
      drive(1, 1, 1, 0, 0, 0);
      chk("lu_strobes", {29'd0, en_pc, en_fd, clr_de}, 32'h1);
      chk("lu_emw", {30'd0, en_em, en_mw}, 32'h3);
      tick();
      chk_valids("lu_valids", 4'b1011);
      chk("lu_stall", stall_cnt, 1);
      chk("lu_flush", flush_cnt, 1);

      // Redirect without stall kills the wrong-path fetch.
      drive(0, 0, 0, 1, 0, 0);
      chk("rd_strobes", {30'd0, en_pc, clr_fd}, 32'h3);
      chk("rd_clrde", clr_de, 0);
      tick();
      chk_valids("rd_valids", 4'b0101);
      chk("rd_flush", flush_cnt, 2);

      // Redirect under stall is ignored.
      drive(0, 1, 0, 1, 0, 0);
      chk("rds_strobes", {28'd0, en_pc, en_fd, clr_fd, en_de}, 0);
      tick();
      chk("rds_flush", flush_cnt, 2);
      chk("rds_stall", stall_cnt, 2);
      chk_valids("rds_valids", 4'b0110);

      // Memory wait with a pending redirect.
      drive(0, 0, 0, 1, 0, 1);
      chk("mw0_strobes", {25'd0, en_pc, en_fd, clr_fd, en_de, clr_de, en_em, en_mw}, 0);
      chk("mw0_state", state, 1);
      tick();
      for (int c = 1; c < 3; c++) begin
         chk($sformatf("mw%0d_state", c), state, 2);
         chk($sformatf("mw%0d_en", c), {28'd0, en_pc, en_fd, en_em, en_mw}, 0);
         chk_valids($sformatf("mw%0d_valids", c), 4'b0110);
         tick();
      end
      chk("mw_stall", stall_cnt, 5);
      drive(0, 0, 0, 1, 0, 0);
      chk("mwx_state", state, 2);
      chk("mwx_strobes", {30'd0, en_pc, clr_fd}, 32'h3);
      tick();
      chk("mwx_state_run", state, 1);
      chk("mwx_stall", stall_cnt, 5);
      chk("mwx_flush", flush_cnt, 3);
      chk_valids("mwx_valids", 4'b0011);
      chk("mwx_retire", retire_cnt, 3);

      // Refill, then two fetch-busy cycles open a two-instruction retire gap.
      drive(0, 0, 0, 0, 0, 0);
      repeat (4) tick();
      chk_valids("refill_valids", 4'b1111);
      chk("refill_retire", retire_cnt, 5);
      drive(0, 0, 0, 0, 1, 0);
      chk("fb_strobes", {29'd0, en_pc, clr_fd, en_de}, 32'h3);
      tick();
      tick();
      chk_valids("fb_valids", 4'b0011);
      chk("fb_retire", retire_cnt, 7);
      chk("fb_stall", stall_cnt, 7);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("gap_retire_a", retire_cnt, 9);
      tick();
      tick();
      chk("gap_retire_b", retire_cnt, 9);
      tick();
      chk("gap_retire_c", retire_cnt, 10);

      // Saturation on the 4-bit instance.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      chk("sat_state", state4, 1);
      drive(1, 0, 0, 0, 0, 0);
      repeat (14) tick();
      chk("sat_pre4", stall_cnt4, 14);
      chk("sat_pre32", stall_cnt, 14);
      repeat (3) tick();
      chk("sat_post4", stall_cnt4, 15);
      chk("sat_post32", stall_cnt, 17);

      // Reset in the middle of a memory wait.
      drive(0, 0, 0, 0, 0, 1);
      tick();
      chk("mwr_state", state, 2);
      rst_n = 1'b0;
      tick();
      chk("mwr_state_boot", state, 0);
      chk("mwr_cnts", stall_cnt | flush_cnt | retire_cnt, 0);
      chk("mwr_cnts4", {20'd0, stall_cnt4, flush_cnt4, retire_cnt4}, 0);
      chk_valids("mwr_valids", 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
